// File: rtl/condlogic.sv
// condlogic -- condition-execution unit of the multi-cycle ARM core.
//
// Holds the architectural NZCV flags and the per-instruction condition-pass
// bit, and gates the decoder's write requests into the final datapath enables.
//
// Ports
//    clk          system clock, rising edge
//    reset        asynchronous, active-high reset
//    Cond         Instr[31:28] of the instruction in the IR
//    ALUFlags     {N,Z,C,V} from the ALU, valid in the ALU cycle
//    FlagW        flag-write request: bit1 = N,Z ; bit0 = C,V
//    PCS          PC-write request (branch or Rd==PC)
//    NextPC       unconditional PC+4 write during fetch
//    RegW         register-file write request
//    MemW         memory write request
//    IRWrite      fetch strobe, high for the fetch cycle of each instruction
//    Flags        current architectural {N,Z,C,V}
//    CondEx       registered condition-pass bit of the current instruction
//    PCWrite      final PC enable
//    RegWrite     final register-file enable
//    MemWrite     final memory write enable
//    ExecCount    (COND_PERF_CNT_EN only) decodes whose condition passed
//    SquashCount  (COND_PERF_CNT_EN only) decodes whose condition failed
//
// Build option: define COND_PERF_CNT_EN to add the two CNT_W-bit counters.

module condlogic #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             NextPC,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             IRWrite,
`ifdef COND_PERF_CNT_EN
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SquashCount,
`endif
   output logic [3:0]       Flags,
   output logic             CondEx,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite
);

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("condlogic: CNT_W must be at least 1");
   end

   logic [3:0] flags_q, flags_d;
   logic       condex_q, condex_d;
   logic       dec_q;
   logic       cond_pass;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      cond_pass = 1'b1;
      case (Cond)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = ~z;
         4'b0010: cond_pass = c;
         4'b0011: cond_pass = ~c;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = ~n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = ~v;
         4'b1000: cond_pass = c & ~z;
         4'b1001: cond_pass = ~c | z;
         4'b1010: cond_pass = (n == v);
         4'b1011: cond_pass = (n != v);
         4'b1100: cond_pass = ~z & (n == v);
         4'b1101: cond_pass = z | (n != v);
         default: cond_pass = 1'b1;   // AL and the unconditional space
      endcase
   end

   // CondEx is captured only at the end of the decode cycle, so an
   // instruction's own flag write cannot change its own pass bit.
   always_comb begin
      condex_d = condex_q;
      if (dec_q) condex_d = cond_pass;
   end

   always_comb begin
      flags_d = flags_q;
      if (FlagW[1] & condex_q) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0] & condex_q) flags_d[1:0] = ALUFlags[1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
         dec_q    <= 1'b0;
      end else begin
         flags_q  <= flags_d;
         condex_q <= condex_d;
         dec_q    <= IRWrite;
      end
   end

`ifdef COND_PERF_CNT_EN
   logic [CNT_W-1:0] exec_cnt_q, squash_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exec_cnt_q   <= '0;
         squash_cnt_q <= '0;
      end else if (dec_q) begin
         if (cond_pass) exec_cnt_q   <= exec_cnt_q + CNT_W'(1);
         else           squash_cnt_q <= squash_cnt_q + CNT_W'(1);
      end
   end

   assign ExecCount   = exec_cnt_q;
   assign SquashCount = squash_cnt_q;
`endif

   assign Flags    = flags_q;
   assign CondEx   = condex_q;
   assign PCWrite  = NextPC | (PCS & condex_q);
   assign RegWrite = RegW & condex_q;
   assign MemWrite = MemW & condex_q;

endmodule

// File: tb/tb_condlogic.sv
module tb_condlogic;

   localparam int TB_CNT_W = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, NextPC, RegW, MemW, IRWrite;
   logic [3:0] Flags;
   logic       CondEx, PCWrite, RegWrite, MemWrite;
`ifdef COND_PERF_CNT_EN
   logic [TB_CNT_W-1:0] ExecCount, SquashCount;
`endif

   condlogic #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
      .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
      .IRWrite(IRWrite),
`ifdef COND_PERF_CNT_EN
      .ExecCount(ExecCount), .SquashCount(SquashCount),
`endif
      .Flags(Flags), .CondEx(CondEx), .PCWrite(PCWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference condition check: even codes test a base predicate, odd codes
   // invert it; the 111x pair is always taken.
   function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
      bit nn, zz, cc, vv, base;
      nn = f[3]; zz = f[2]; cc = f[1]; vv = f[0];
      case (int'(c) / 2)
         0: base = zz;
         1: base = cc;
         2: base = nn;
         3: base = vv;
         4: base = cc && !zz;
         5: base = (nn == vv);
         6: base = !zz && (nn == vv);
         default: return 1'b1;
      endcase
      return (c % 2 == 1) ? !base : base;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00; PCS = 0; NextPC = 0;
      RegW = 0; MemW = 0; IRWrite = 0;
   endtask

   // fetch cycle then decode cycle; CondEx is valid on return
   task automatic do_instr(input logic [3:0] c);
      Cond = c; IRWrite = 1; tick();
      IRWrite = 0; tick();
   endtask

   task automatic set_flags(input logic [3:0] f);
      do_instr(4'hE);
      FlagW = 2'b11; ALUFlags = f; tick();
      FlagW = 2'b00; ALUFlags = 4'h0;
   endtask

   typedef struct {
      logic [3:0] flags;
      logic [3:0] cond;
      logic       exp;
   } vec_t;

   vec_t vecs[$];

   // random-phase model state
   logic [3:0] m_flags;
   logic       m_condex, m_dec;
   int         m_exec, m_squash;

   initial begin
      idle_inputs();
      reset = 1; FlagW = 2'b11; RegW = 1; MemW = 1; PCS = 1; NextPC = 0;
      #12;
      chk("rst_flags", Flags, 0);
      chk("rst_condex", CondEx, 0);
      chk("rst_regwrite", RegWrite, 0);
      chk("rst_memwrite", MemWrite, 0);
      chk("rst_pcwrite_lo", PCWrite, 0);
      NextPC = 1; #1;
      chk("rst_pcwrite_hi", PCWrite, 1);
      tick();
      chk("rst_flags_hold", Flags, 0);
      reset = 0; idle_inputs(); tick();

      // EQ with zero flags squashes everything except NextPC
      do_instr(4'b0000);
      RegW = 1; MemW = 1; PCS = 1; #1;
      chk("eq_condex", CondEx, 0);
      chk("eq_regwrite", RegWrite, 0);
      chk("eq_memwrite", MemWrite, 0);
      chk("eq_pcwrite", PCWrite, 0);
      idle_inputs();

      set_flags(4'b0100);
      chk("flagw11", Flags, 4'b0100);
      do_instr(4'b0000);
      chk("eq_pass", CondEx, 1);
      RegW = 1; #1; chk("regw_follow1", RegWrite, 1);
      RegW = 0; #1; chk("regw_follow0", RegWrite, 0);
      idle_inputs();

      // partial flag write: only C,V
      set_flags(4'b1000);
      do_instr(4'hE);
      FlagW = 2'b01; ALUFlags = 4'b0011; tick();
      chk("flagw01", Flags, 4'b1011);
      idle_inputs();

      // own flag write must not disturb the latched CondEx
      set_flags(4'b0000);
      do_instr(4'b0001);                 // NE passes with Z=0
      FlagW = 2'b11; ALUFlags = 4'b0100; tick();
      chk("own_update_condex", CondEx, 1);
      chk("own_update_flags", Flags, 4'b0100);
      idle_inputs(); tick();
      chk("condex_hold", CondEx, 1);

      // back-to-back fetch: second fetch cycle is also a decode cycle
      set_flags(4'b0100);
      Cond = 4'b0001; IRWrite = 1; tick(); tick();
      chk("b2b_load", CondEx, 0);
      Cond = 4'b0000; IRWrite = 0; tick();
      chk("b2b_second", CondEx, 1);
      idle_inputs();

      // reset mid-instruction suppresses in-flight requests immediately
      RegW = 1; MemW = 1; PCS = 1; #1;
      chk("pre_rst_regwrite", RegWrite, 1);
      #2 reset = 1; #1;
      chk("midrst_regwrite", RegWrite, 0);
      chk("midrst_memwrite", MemWrite, 0);
      chk("midrst_pcwrite", PCWrite, 0);
      chk("midrst_flags", Flags, 0);
      tick(); reset = 0; idle_inputs(); tick();

      // table-driven condition vectors
      vecs.push_back('{4'b0000, 4'b0000, 1'b0});
      vecs.push_back('{4'b0100, 4'b0000, 1'b1});
      vecs.push_back('{4'b0100, 4'b0001, 1'b0});
      vecs.push_back('{4'b0010, 4'b0010, 1'b1});
      vecs.push_back('{4'b0000, 4'b0011, 1'b1});
      vecs.push_back('{4'b1000, 4'b0100, 1'b1});
      vecs.push_back('{4'b1000, 4'b0101, 1'b0});
      vecs.push_back('{4'b0001, 4'b0110, 1'b1});
      vecs.push_back('{4'b0001, 4'b0111, 1'b0});
      vecs.push_back('{4'b0010, 4'b1000, 1'b1});
      vecs.push_back('{4'b0110, 4'b1000, 1'b0});
      vecs.push_back('{4'b0110, 4'b1001, 1'b1});
      vecs.push_back('{4'b0010, 4'b1001, 1'b0});
      vecs.push_back('{4'b1000, 4'b1010, 1'b0});
      vecs.push_back('{4'b1001, 4'b1010, 1'b1});
      vecs.push_back('{4'b1000, 4'b1011, 1'b1});
      vecs.push_back('{4'b0000, 4'b1100, 1'b1});
      vecs.push_back('{4'b1001, 4'b1100, 1'b1});
      vecs.push_back('{4'b0100, 4'b1100, 1'b0});
      vecs.push_back('{4'b0100, 4'b1101, 1'b1});
      vecs.push_back('{4'b0000, 4'b1101, 1'b0});
      vecs.push_back('{4'b0000, 4'b1110, 1'b1});
      vecs.push_back('{4'b1000, 4'b1111, 1'b1});
      vecs.push_back('{4'b0000, 4'b1111, 1'b1});
      foreach (vecs[i]) begin
         set_flags(vecs[i].flags);
         do_instr(vecs[i].cond);
         RegW = 1; MemW = 1; PCS = 1; #1;
         chk($sformatf("vec%0d_condex", i), CondEx, vecs[i].exp);
         chk($sformatf("vec%0d_regwrite", i), RegWrite, vecs[i].exp);
         chk($sformatf("vec%0d_pcwrite", i), PCWrite, vecs[i].exp);
         idle_inputs();
      end

`ifdef COND_PERF_CNT_EN
      reset = 1; #2; reset = 0; idle_inputs(); tick();
      for (int i = 0; i < 16; i++) do_instr(4'hE);
      chk("exec_wrap", ExecCount, 0);
      chk("squash_zero", SquashCount, 0);
      for (int i = 0; i < 3; i++) do_instr(4'b0000);   // Z=0 -> EQ fails
      chk("squash_three", SquashCount, 3);
      chk("exec_still_zero", ExecCount, 0);
`endif

      // randomized run against the model
      idle_inputs();
      reset = 1; #2; reset = 0; tick();
      m_flags = 0; m_condex = 0; m_dec = 0; m_exec = 0; m_squash = 0;
      for (int i = 0; i < 2000; i++) begin
         Cond = 4'($urandom); ALUFlags = 4'($urandom); FlagW = 2'($urandom);
         PCS = 1'($urandom); NextPC = 1'($urandom); RegW = 1'($urandom);
         MemW = 1'($urandom); IRWrite = ($urandom_range(0, 2) == 0);
         #1;
         chk("rnd_flags", Flags, m_flags);
         chk("rnd_condex", CondEx, m_condex);
         chk("rnd_pcwrite", PCWrite, NextPC || (PCS && m_condex));
         chk("rnd_regwrite", RegWrite, RegW && m_condex);
         chk("rnd_memwrite", MemWrite, MemW && m_condex);
`ifdef COND_PERF_CNT_EN
         chk("rnd_exec", ExecCount, m_exec % 16);
         chk("rnd_squash", SquashCount, m_squash % 16);
`endif
         @(posedge clk);
         begin
            logic [3:0] nf;
            nf = m_flags;
            if (FlagW[1] && m_condex) nf[3:2] = ALUFlags[3:2];
            if (FlagW[0] && m_condex) nf[1:0] = ALUFlags[1:0];
            if (m_dec) begin
               if (ref_pass(Cond, m_flags)) m_exec++; else m_squash++;
               m_condex = ref_pass(Cond, m_flags);
            end
            m_flags = nf;
            m_dec = IRWrite;
         end
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
